// File: rtl/bin_stream_reader.sv
// Two-pass reader of the 28x28 bin buffer. A scan pass finds min/max for the
// threshold, then a stream pass emits one byte per bin on an AXI4-Stream master.
module bin_stream_reader #(
  parameter int NUM_PIX    = 784,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              binarize,
  output logic              busy,
  output logic              done,
  output logic [7:0]        thresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int CNT_W = $clog2(NUM_PIX + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 2);
  localparam logic [CNT_W-1:0] NUM_PIX_C  = CNT_W'(NUM_PIX);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(NUM_PIX - 1);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_THRESH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;
  logic [7:0]       thresh_q, thresh_d;
  logic             bin_q, bin_d;
  logic             rvalid_q;
  logic             rlast_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic [7:0]       fifo_data_q [FIFO_DEPTH];
  logic             fifo_last_q [FIFO_DEPTH];

  logic [7:0]       pix;
  logic [7:0]       out_pix;
  logic [8:0]       sum;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ_after;

  // Any nonzero bit above the low byte saturates the bin to full scale.
  assign pix     = (|mem_rdata[DATA_W-1:8]) ? 8'hFF : mem_rdata[7:0];
  assign out_pix = bin_q ? ((pix > thresh_q) ? 8'hFF : 8'h00) : pix;
  assign sum     = {1'b0, min_q} + {1'b0, max_q};

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[rd_ptr_q];
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign push          = (state_q == S_STREAM) & rvalid_q;

  // Entries held plus the read already in flight, less the beat leaving now.
  assign occ_after = count_q + OCC_W'(rvalid_q) - OCC_W'(pop);

  assign thresh   = thresh_q;
  assign busy     = (state_q != S_IDLE);
  assign mem_addr = mem_rd_en ? ADDR_W'(addr_q) : '0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    min_d     = min_q;
    max_d     = max_q;
    thresh_d  = thresh_q;
    bin_d     = bin_q;
    mem_rd_en = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = binarize;
          min_d   = 8'hFF;
          max_d   = 8'h00;
          addr_d  = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (addr_q < NUM_PIX_C) begin
          mem_rd_en = 1'b1;
          addr_d    = addr_q + 1'b1;
        end else begin
          state_d = S_THRESH;
        end
        if (rvalid_q) begin
          if (pix < min_q) min_d = pix;
          if (pix > max_q) max_d = pix;
        end
      end

      S_THRESH: begin
        thresh_d = 8'(sum >> 1);
        addr_d   = '0;
        state_d  = S_STREAM;
      end

      S_STREAM: begin
        if ((addr_q < NUM_PIX_C) && (occ_after < DEPTH_C)) begin
          mem_rd_en = 1'b1;
          addr_d    = addr_q + 1'b1;
        end
        if (pop && m_axis_tlast) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    if (push) wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      min_q    <= 8'hFF;
      max_q    <= 8'h00;
      thresh_q <= 8'h00;
      bin_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      min_q    <= min_d;
      max_q    <= max_d;
      thresh_q <= thresh_d;
      bin_q    <= bin_d;
      rvalid_q <= mem_rd_en;
      rlast_q  <= mem_rd_en & (addr_q == LAST_ADDR);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= out_pix;
      fifo_last_q[wr_ptr_q] <= rlast_q;
    end
  end

endmodule

// File: tb/tb_bin_stream_reader.sv
// Randomised scoreboard bench for bin_stream_reader: a frame-level reference
// model fills the expected-beat queue and a monitor checks every handshake.
module tb_bin_stream_reader;

  localparam int NUM_PIX    = 784;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              binarize = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        thresh;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  bin_stream_reader #(
    .NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .binarize(binarize),
    .busy(busy), .done(done), .thresh(thresh),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  beat_t             exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int first_cyc = -1;
  int last_cyc = 0;
  bit tready_rand = 1'b0;

  // SRAM model: data one cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = tready_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [DATA_W-1:0] w);
    return (w[DATA_W-1:8] != 0) ? 8'hFF : w[7:0];
  endfunction

  // Frame-level reference: threshold from the extremes, then one beat per bin.
  task automatic build_expect(input bit bin, output logic [7:0] th);
    int mn = 255;
    int mx = 0;
    int p;
    beat_t b;
    for (int i = 0; i < NUM_PIX; i++) begin
      p = pix_of(mem[i]);
      if (p < mn) mn = p;
      if (p > mx) mx = p;
    end
    th = 8'((mn + mx) / 2);
    for (int i = 0; i < NUM_PIX; i++) begin
      p = pix_of(mem[i]);
      b.data = bin ? ((p > th) ? 8'hFF : 8'h00) : 8'(p);
      b.last = (i == NUM_PIX - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.data);
          chk("tlast", m_axis_tlast, e.last);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beat_cnt++;
      end
      if (done) done_cnt++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_thresh"}, thresh, 0);
  endtask

  task automatic pulse_start(input bit bin);
    @(posedge clk);
    #1;
    binarize = bin;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    binarize = ~bin;
  endtask

  task automatic run_frame(input string name, input bit bin, input bit rand_ready,
                           input bit extra_start, input int req_thresh);
    logic [7:0] th;
    int budget;
    build_expect(bin, th);
    if (req_thresh >= 0) chk({name, "_model_thresh"}, th, req_thresh);
    beat_cnt    = 0;
    done_cnt    = 0;
    first_cyc   = -1;
    tready_rand = rand_ready;
    pulse_start(bin);
    budget = 0;
    while (!done && budget < 20000) begin
      @(negedge clk);
      budget++;
      start = (extra_start && budget == 1000);
    end
    start = 1'b0;
    chk({name, "_done_seen"}, done, 1);
    @(negedge clk);
    chk({name, "_done_width"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_beats"}, beat_cnt, NUM_PIX);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_thresh"}, thresh, th);
    if (!rand_ready) chk({name, "_throughput"}, last_cyc - first_cyc, NUM_PIX - 1);
    exp_q.delete();
    tready_rand = 1'b0;
    $display("frame %s bin=%0d thresh=%0h beats=%0d checks=%0d errors=%0d",
             name, bin, thresh, beat_cnt, checks, errors);
  endtask

  initial begin
    logic [7:0] th;
    int budget;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NUM_PIX; i++) mem[i] = DATA_W'(i & 8'hFF);
    run_frame("ramp_raw", 1'b0, 1'b0, 1'b0, 8'h7F);

    for (int i = 0; i < NUM_PIX; i++) mem[i] = DATA_W'($urandom_range(8'h10, 8'h90));
    mem[0] = 32'h10; mem[1] = 32'h90; mem[2] = 32'h50; mem[3] = 32'h51;
    run_frame("window_bin", 1'b1, 1'b0, 1'b0, 8'h50);

    for (int i = 0; i < NUM_PIX; i++) mem[i] = 32'h40;
    run_frame("flat_bin", 1'b1, 1'b0, 1'b0, 8'h40);

    for (int i = 0; i < NUM_PIX; i++) mem[i] = DATA_W'($urandom_range(0, 8'h7F));
    mem[5] = 32'h0000_0123;
    mem[400] = 32'h8000_0001;
    run_frame("saturate_raw", 1'b0, 1'b0, 1'b0, (0 + 255) / 2 + 0 * 1);

    for (int i = 0; i < NUM_PIX; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? $urandom : DATA_W'($urandom_range(0, 255));
    run_frame("rand_ready", 1'($urandom_range(0, 1)), 1'b1, 1'b1, -1);

    // Reset in the middle of streaming, then a clean frame.
    for (int i = 0; i < NUM_PIX; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    build_expect(1'b0, th);
    beat_cnt  = 0;
    first_cyc = -1;
    pulse_start(1'b0);
    budget = 0;
    while (beat_cnt < 300 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    chk("midreset_reached_beat_300", (beat_cnt >= 300), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    $display("frame midreset stopped at beat=%0d checks=%0d errors=%0d", beat_cnt, checks, errors);

    run_frame("after_reset", 1'b1, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
